lif_wta_n: RTL and testbench

Parametrised N-channel leaky-integrate-and-fire winner-take-all selector, the generalised successor of the 3-way relay LIF selector. Each channel integrates an externally supplied current sample with leak and saturation. When any membrane crosses threshold, the block picks the highest-voltage channel, resets all membranes and enters a programmable refractory window. It sits between the per-channel current generators and the relay/mode control logic.

---
 rtl/lif_pkg.sv | 30 +++
 rtl/lif_neuron.sv | 32 +++
 rtl/lif_wta_n.sv | 111 +++++++++++
 tb/tb_lif_wta_n.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared constants, FSM state type and saturating membrane arithmetic for the LIF winner-take-all selector.
package lif_pkg;

  localparam int unsigned LIF_N_CH      = 4;
  localparam int unsigned LIF_IN_W      = 8;
  localparam int unsigned LIF_V_W       = 16;
  localparam int unsigned LIF_THRESHOLD = 400;
  localparam int unsigned LIF_LEAK      = 4;
  localparam int unsigned LIF_REFRACT   = 3;

  typedef enum logic [0:0] {
    INTEGRATE  = 1'b0,
    REFRACTORY = 1'b1
  } lif_state_t;

  function automatic logic [31:0] floor_sub(input logic [31:0] v, input logic [31:0] d);
    return (v >= d) ? (v - d) : '0;
  endfunction

  // The 33-bit sum cannot wrap for any membrane width up to 32 bits.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (s > lim) ? lim[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/lif_neuron.sv
// One leaky-integrate-and-fire membrane: leak floored at 0, then saturating add of the input current.
module lif_neuron
  import lif_pkg::*;
#(
  parameter int unsigned IN_W = LIF_IN_W,
  parameter int unsigned V_W  = LIF_V_W,
  parameter int unsigned LEAK = LIF_LEAK
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_en,
  input  logic            i_clr,
  input  logic            i_valid,
  input  logic [IN_W-1:0] i_cur,
  output logic [V_W-1:0]  o_v_next
);

  logic [V_W-1:0]  r_v;
  logic [IN_W-1:0] w_i;

  assign w_i      = i_valid ? i_cur : '0;
  assign o_v_next = V_W'(sat_add(floor_sub(32'(r_v), 32'(LEAK)), 32'(w_i), V_W));

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_v <= '0;
    end else if (i_en) begin
      r_v <= o_v_next;
    end
  end

endmodule

// File: rtl/lif_wta_n.sv
// N-channel LIF winner-take-all: integrates currents, picks the highest membrane on any threshold
// crossing, clears all membranes and blocks input for a programmable refractory window.
module lif_wta_n
  import lif_pkg::*;
#(
  parameter int unsigned N_CH      = LIF_N_CH,
  parameter int unsigned IN_W      = LIF_IN_W,
  parameter int unsigned V_W       = LIF_V_W,
  parameter int unsigned THRESHOLD = LIF_THRESHOLD,
  parameter int unsigned LEAK      = LIF_LEAK,
  parameter int unsigned REFRACT   = LIF_REFRACT,
  localparam int unsigned WW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_CH*IN_W-1:0] in_current,
  output logic                 out_valid,
  output logic [WW-1:0]        winner,
  output logic [V_W-1:0]       winner_v,
  output logic                 busy
);

  localparam int unsigned CW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  lif_state_t     r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_out_valid;
  logic [WW-1:0]  r_winner;
  logic [V_W-1:0] r_winner_v;

  logic [V_W-1:0] w_vn [N_CH];
  logic           w_accept;
  logic           w_spike;
  logic [WW-1:0]  w_arg;
  logic [V_W-1:0] w_argv;

  assign in_ready = (r_state == INTEGRATE);
  assign busy     = (r_state == REFRACTORY);
  assign w_accept = in_valid && in_ready;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    lif_neuron #(
      .IN_W (IN_W),
      .V_W  (V_W),
      .LEAK (LEAK)
    ) u_neuron (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_en     (in_ready),
      .i_clr    (w_spike),
      .i_valid  (w_accept),
      .i_cur    (in_current[g*IN_W +: IN_W]),
      .o_v_next (w_vn[g])
    );
  end

  // Strict '>' keeps the lowest index on ties; the argmax spans every channel, not only spiking ones.
  always_comb begin
    w_arg   = '0;
    w_argv  = w_vn[0];
    w_spike = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (w_vn[i] >= V_W'(THRESHOLD)) w_spike = in_ready;
      if (i > 0 && w_vn[i] > w_argv) begin
        w_argv = w_vn[i];
        w_arg  = WW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= INTEGRATE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_winner    <= '0;
      r_winner_v  <= '0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        INTEGRATE: begin
          if (w_spike) begin
            r_out_valid <= 1'b1;
            r_winner    <= w_arg;
            r_winner_v  <= w_argv;
            if (REFRACT > 0) begin
              r_state <= REFRACTORY;
              r_cnt   <= CW'(REFRACT);
            end
          end
        end
        REFRACTORY: begin
          if (r_cnt == CW'(1)) begin
            r_state <= INTEGRATE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= INTEGRATE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign winner    = r_winner;
  assign winner_v  = r_winner_v;

endmodule

// File: tb/tb_lif_wta_n.sv
// Directed self-checking bench for lif_wta_n: default instance plus saturating 9-bit variants.
module tb_lif_wta_n;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_current;
  logic        out_valid;
  logic [1:0]  winner;
  logic [15:0] winner_v;
  logic        busy;

  logic        s_valid;
  logic [31:0] s_current;
  logic        s_ready, s_ov, s_busy;
  logic [1:0]  s_win;
  logic [8:0]  s_wv;
  logic        z_ready, z_ov, z_busy;
  logic [1:0]  z_win;
  logic [8:0]  z_wv;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lif_wta_n u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_current(in_current), .out_valid(out_valid), .winner(winner),
    .winner_v(winner_v), .busy(busy)
  );

  lif_wta_n #(.V_W(9), .THRESHOLD(511), .REFRACT(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s_ready),
    .in_current(s_current), .out_valid(s_ov), .winner(s_win),
    .winner_v(s_wv), .busy(s_busy)
  );

  lif_wta_n #(.V_W(9), .THRESHOLD(511), .REFRACT(0)) u_sat0 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(z_ready),
    .in_current(s_current), .out_valid(z_ov), .winner(z_win),
    .winner_v(z_wv), .busy(z_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cur(input int c0, input int c1, input int c2, input int c3);
    in_current = {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    set_cur(200, 200, 200, 200);
    tick();
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_ov got=%0b exp=0", out_valid); end
    total++; if (winner !== 2'd0) begin bad++; $display("FAIL reset_winner got=%0d exp=0", winner); end
    total++; if (winner_v !== 16'd0) begin bad++; $display("FAIL reset_wv got=%0d exp=0", winner_v); end
    total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_ready got=%0b/%0b exp=1/0", in_ready, busy);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_integrate();
    in_valid = 1'b1;
    set_cur(10, 100, 50, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL integ_early_ov step=%0d got=%0b exp=0", i, out_valid); end
    end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL integ_ov got=%0b exp=1", out_valid); end
    total++; if (winner !== 2'd1) begin bad++; $display("FAIL integ_winner got=%0d exp=1", winner); end
    total++; if (winner_v !== 16'd484) begin bad++; $display("FAIL integ_wv got=%0d exp=484", winner_v); end
    total++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL integ_ready got=%0b/%0b exp=0/1", in_ready, busy);
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL integ_pulse got=%0b exp=0", out_valid); end
    total++; if (winner !== 2'd1 || winner_v !== 16'd484) begin
      bad++; $display("FAIL integ_hold got=%0d/%0d exp=1/484", winner, winner_v);
    end
    tick();
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL integ_release got=%0b exp=1", in_ready); end
  endtask

  task automatic test_tie();
    in_valid = 1'b1;
    set_cur(204, 0, 204, 0);
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL tie_early got=%0b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || winner !== 2'd0 || winner_v !== 16'd404) begin
      bad++; $display("FAIL tie_decision got=%0b/%0d/%0d exp=1/0/404", out_valid, winner, winner_v);
    end
  endtask

  // Entered in the first refractory cycle left by test_tie.
  task automatic test_refractory();
    int low = 0;
    in_valid = 1'b1;
    set_cur(255, 255, 255, 255);
    for (int i = 0; i < 10 && in_ready === 1'b0; i++) begin
      low++;
      total++; if (out_valid !== 1'b0 && low > 1) begin bad++; $display("FAIL refr_ov got=%0b exp=0", out_valid); end
      tick();
    end
    total++; if (low !== 3) begin bad++; $display("FAIL refr_len got=%0d exp=3", low); end
    set_cur(0, 0, 204, 0);
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL refr_held got=%0b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || winner !== 2'd2 || winner_v !== 16'd404) begin
      bad++; $display("FAIL refr_next got=%0b/%0d/%0d exp=1/2/404", out_valid, winner, winner_v);
    end
  endtask

  task automatic test_reset_mid_refractory();
    in_valid = 1'b0;
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_pre got=%0b exp=0", in_ready); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_ready got=%0b/%0b exp=1/0", in_ready, busy);
    end
    total++; if (winner !== 2'd0 || winner_v !== 16'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_clear got=%0d/%0d/%0b exp=0/0/0", winner, winner_v, out_valid);
    end
    in_valid = 1'b1;
    set_cur(204, 0, 0, 0);
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_early got=%0b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || winner !== 2'd0 || winner_v !== 16'd404) begin
      bad++; $display("FAIL mid_resume got=%0b/%0d/%0d exp=1/0/404", out_valid, winner, winner_v);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_saturation();
    rst_n = 1'b0;
    s_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    s_valid = 1'b1;
    s_current = 32'd255;
    tick();
    tick();
    total++; if (s_ov !== 1'b0 || z_ov !== 1'b0) begin
      bad++; $display("FAIL sat_early got=%0b/%0b exp=0/0", s_ov, z_ov);
    end
    tick();
    total++; if (s_ov !== 1'b1 || s_win !== 2'd0 || s_wv !== 9'd511) begin
      bad++; $display("FAIL sat_decision got=%0b/%0d/%0d exp=1/0/511", s_ov, s_win, s_wv);
    end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL sat_refr got=%0b exp=0", s_ready); end
    total++; if (z_ov !== 1'b1 || z_wv !== 9'd511 || z_ready !== 1'b1) begin
      bad++; $display("FAIL sat0_first got=%0b/%0d/%0b exp=1/511/1", z_ov, z_wv, z_ready);
    end
    for (int i = 1; i <= 6; i++) begin
      tick();
      total++; if (z_ready !== 1'b1 || z_busy !== 1'b0) begin
        bad++; $display("FAIL sat0_ready step=%0d got=%0b exp=1", i, z_ready);
      end
      total++; if (z_ov !== ((i % 3) == 0)) begin
        bad++; $display("FAIL sat0_period step=%0d got=%0b exp=%0b", i, z_ov, (i % 3) == 0);
      end
    end
    total++; if (z_wv !== 9'd511 || z_win !== 2'd0) begin
      bad++; $display("FAIL sat0_value got=%0d/%0d exp=511/0", z_wv, z_win);
    end
    s_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_current = '0;
    s_valid = 1'b0;
    s_current = '0;
    test_reset();
    test_integrate();
    test_tie();
    test_refractory();
    test_reset_mid_refractory();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
